// File: rtl/matmul_controller.sv
// Address/control sequencer for a DIM x DIM matrix product over 1-cycle-latency operand memories.
// Optional feature macro: MATMUL_CTRL_STALL_EN adds a stall input that freezes the sequence.
module matmul_controller #(
    parameter int unsigned DIM        = 4,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
`ifdef MATMUL_CTRL_STALL_EN
    input  logic                    stall,
`endif
    output logic [ADDR_WIDTH-1:0]   addr_A,
    output logic [ADDR_WIDTH-1:0]   addr_B,
    output logic                    en_Mux,
    output logic                    en_PPReg,
    output logic                    en_FDReg,
    output logic                    out_valid,
    output logic [$clog2(DIM)-1:0]  out_row,
    output logic [$clog2(DIM)-1:0]  out_col,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned IDX_W = $clog2(DIM);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIM - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state;
    logic [IDX_W-1:0]       i, j, k;
    logic [IDX_W-1:0]       i_nxt, j_nxt, k_nxt;
    logic [IDX_W-1:0]       fd_row, fd_col;
    logic [ADDR_WIDTH-1:0]  addr_a_nxt, addr_b_nxt;
    logic                   k_last, j_last, term_last;
    logic                   fd_pend, emit, stall_w;

`ifdef MATMUL_CTRL_STALL_EN
    assign stall_w = stall;
`else
    assign stall_w = 1'b0;
`endif

    // Next term indices and their operand addresses.
    always_comb begin
        k_last     = (k == LAST);
        j_last     = (j == LAST);
        term_last  = k_last && j_last && (i == LAST);
        k_nxt      = k_last ? '0 : k + IDX_W'(1);
        j_nxt      = j;
        i_nxt      = i;
        if (k_last) begin
            j_nxt = j_last ? '0 : j + IDX_W'(1);
            if (j_last) begin
                i_nxt = i + IDX_W'(1);
            end
        end
        addr_a_nxt = ADDR_WIDTH'(i_nxt) * ADDR_WIDTH'(DIM) + ADDR_WIDTH'(k_nxt);
        addr_b_nxt = ADDR_WIDTH'(k_nxt) * ADDR_WIDTH'(DIM) + ADDR_WIDTH'(j_nxt);
        // A final-data load seen under stall is remembered and reported on release.
        emit       = (en_FDReg | fd_pend) & ~stall_w;
    end

    // Sequencer FSM, counters and the one-cycle control pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            addr_A    <= '0;
            addr_B    <= '0;
            en_Mux    <= 1'b0;
            en_PPReg  <= 1'b0;
            en_FDReg  <= 1'b0;
            out_valid <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fd_row    <= '0;
            fd_col    <= '0;
            fd_pend   <= 1'b0;
        end else begin
            en_Mux    <= 1'b0;
            en_PPReg  <= 1'b0;
            en_FDReg  <= 1'b0;
            done      <= 1'b0;
            out_valid <= emit;
            fd_pend   <= (en_FDReg | fd_pend) & stall_w;
            if (emit) begin
                out_row <= fd_row;
                out_col <= fd_col;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RUN;
                        i      <= '0;
                        j      <= '0;
                        k      <= '0;
                        addr_A <= '0;
                        addr_B <= '0;
                        busy   <= 1'b1;
                    end
                end
                RUN: begin
                    if (!stall_w) begin
                        en_PPReg <= 1'b1;
                        en_Mux   <= (k != '0);
                        en_FDReg <= k_last;
                        if (k_last) begin
                            fd_row <= i;
                            fd_col <= j;
                        end
                        if (term_last) begin
                            state <= DRAIN;
                        end else begin
                            i      <= i_nxt;
                            j      <= j_nxt;
                            k      <= k_nxt;
                            addr_A <= addr_a_nxt;
                            addr_B <= addr_b_nxt;
                        end
                    end
                end
                DRAIN: begin
                    if (!stall_w) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_controller.sv
// Scoreboard bench: DIM=2 and DIM=4 controllers driving a behavioural MAC data path.
`timescale 1ns/1ps
module tb_matmul_controller;

    localparam int unsigned AW = 4;

    typedef struct { int aa; int ab; int mux; int fd; } term_t;
    typedef struct { int row; int col; int val; } res_t;

    logic clk;
    logic reset_n;
    logic start2, start4;
`ifdef MATMUL_CTRL_STALL_EN
    logic stall2;
`endif

    logic [AW-1:0] addr_A_2, addr_B_2, addr_A_4, addr_B_4;
    logic en_Mux_2, en_PPReg_2, en_FDReg_2, out_valid_2, busy_2, done_2;
    logic en_Mux_4, en_PPReg_4, en_FDReg_4, out_valid_4, busy_4, done_4;
    logic [0:0] out_row_2, out_col_2;
    logic [1:0] out_row_4, out_col_4;

    matmul_controller #(.DIM(2), .ADDR_WIDTH(AW)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2),
`ifdef MATMUL_CTRL_STALL_EN
        .stall(stall2),
`endif
        .addr_A(addr_A_2), .addr_B(addr_B_2), .en_Mux(en_Mux_2), .en_PPReg(en_PPReg_2),
        .en_FDReg(en_FDReg_2), .out_valid(out_valid_2), .out_row(out_row_2),
        .out_col(out_col_2), .busy(busy_2), .done(done_2)
    );

    matmul_controller #(.DIM(4), .ADDR_WIDTH(AW)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .start(start4),
`ifdef MATMUL_CTRL_STALL_EN
        .stall(1'b0),
`endif
        .addr_A(addr_A_4), .addr_B(addr_B_4), .en_Mux(en_Mux_4), .en_PPReg(en_PPReg_4),
        .en_FDReg(en_FDReg_4), .out_valid(out_valid_4), .out_row(out_row_4),
        .out_col(out_col_4), .busy(busy_4), .done(done_4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Operand memories (index 0: DIM=2, index 1: DIM=4) and the MAC data path they feed.
    int a_m[2][16];
    int b_m[2][16];
    int da2, db2, pp2, fd2, da4, db4, pp4, fd4;

    always @(posedge clk) begin
        da2 <= a_m[0][addr_A_2];
        db2 <= b_m[0][addr_B_2];
        if (en_PPReg_2) pp2 <= (en_Mux_2 ? pp2 : 0) + da2 * db2;
        if (en_FDReg_2) fd2 <= (en_Mux_2 ? pp2 : 0) + da2 * db2;
        da4 <= a_m[1][addr_A_4];
        db4 <= b_m[1][addr_B_4];
        if (en_PPReg_4) pp4 <= (en_Mux_4 ? pp4 : 0) + da4 * db4;
        if (en_FDReg_4) fd4 <= (en_Mux_4 ? pp4 : 0) + da4 * db4;
    end

    term_t tq2[$], tq4[$];
    res_t  rq2[$], rq4[$];
    int    bq2[$], bq4[$];
    int    prev_aa[2], prev_ab[2], bcnt[2];
    int    checks = 0;
    int    failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain matrix product plus the term order i,j,k with k innermost.
    task automatic push_product(input int sel, input int extra);
        int d;
        int s;
        term_t t;
        res_t r;
        d = (sel == 0) ? 2 : 4;
        for (int i = 0; i < d; i++) begin
            for (int j = 0; j < d; j++) begin
                s = 0;
                for (int k = 0; k < d; k++) begin
                    s += a_m[sel][i*d+k] * b_m[sel][k*d+j];
                    t.aa = i*d + k;
                    t.ab = k*d + j;
                    t.mux = (k != 0) ? 1 : 0;
                    t.fd = (k == d-1) ? 1 : 0;
                    if (sel == 0) tq2.push_back(t); else tq4.push_back(t);
                end
                r.row = i;
                r.col = j;
                r.val = s;
                if (sel == 0) rq2.push_back(r); else rq4.push_back(r);
            end
        end
        if (sel == 0) bq2.push_back(d*d*d + 2 + extra); else bq4.push_back(d*d*d + 2 + extra);
    endtask

    task automatic mon(input int sel, input logic pp, input logic mux, input logic fdr,
                       input logic ov, input logic dn, input logic bz, input int aa,
                       input int ab, input int row, input int col, input int fdv);
        term_t t;
        res_t r;
        int n;
        string p;
        p = (sel == 0) ? "d2_" : "d4_";
        if (pp) begin
            n = (sel == 0) ? tq2.size() : tq4.size();
            chk({p, "term_expected"}, (n > 0) ? 1 : 0, 1);
            if (n > 0) begin
                if (sel == 0) t = tq2.pop_front(); else t = tq4.pop_front();
                chk({p, "addr_A"}, prev_aa[sel], t.aa);
                chk({p, "addr_B"}, prev_ab[sel], t.ab);
                chk({p, "en_Mux"}, mux ? 1 : 0, t.mux);
                chk({p, "en_FDReg"}, fdr ? 1 : 0, t.fd);
            end
        end else begin
            chk({p, "idle_enables"}, (mux | fdr) ? 1 : 0, 0);
        end
        prev_aa[sel] = aa;
        prev_ab[sel] = ab;
        if (ov) begin
            n = (sel == 0) ? rq2.size() : rq4.size();
            chk({p, "result_expected"}, (n > 0) ? 1 : 0, 1);
            if (n > 0) begin
                if (sel == 0) r = rq2.pop_front(); else r = rq4.pop_front();
                chk({p, "out_row"}, row, r.row);
                chk({p, "out_col"}, col, r.col);
                chk({p, "result"}, fdv, r.val);
            end
        end
        if (dn) begin
            chk({p, "done_with_valid"}, ov ? 1 : 0, 1);
            chk({p, "done_results_left"}, (sel == 0) ? rq2.size() : rq4.size(), 0);
        end
        if (bz) begin
            bcnt[sel]++;
        end else if (bcnt[sel] != 0) begin
            n = (sel == 0) ? bq2.size() : bq4.size();
            chk({p, "busy_expected"}, (n > 0) ? 1 : 0, 1);
            if (n > 0) chk({p, "busy_cycles"}, bcnt[sel], (sel == 0) ? bq2.pop_front() : bq4.pop_front());
            bcnt[sel] = 0;
        end
    endtask

    initial begin
        bcnt[0] = 0;
        bcnt[1] = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                bcnt[0] = 0;
                bcnt[1] = 0;
            end else begin
                mon(0, en_PPReg_2, en_Mux_2, en_FDReg_2, out_valid_2, done_2, busy_2,
                    int'(addr_A_2), int'(addr_B_2), int'(out_row_2), int'(out_col_2), fd2);
                mon(1, en_PPReg_4, en_Mux_4, en_FDReg_4, out_valid_4, done_4, busy_4,
                    int'(addr_A_4), int'(addr_B_4), int'(out_row_4), int'(out_col_4), fd4);
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_addr_A_2"}, addr_A_2, 0);     chk({tag, "_addr_B_2"}, addr_B_2, 0);
        chk({tag, "_en_Mux_2"}, en_Mux_2, 0);     chk({tag, "_en_PPReg_2"}, en_PPReg_2, 0);
        chk({tag, "_en_FDReg_2"}, en_FDReg_2, 0); chk({tag, "_out_valid_2"}, out_valid_2, 0);
        chk({tag, "_out_row_2"}, out_row_2, 0);   chk({tag, "_out_col_2"}, out_col_2, 0);
        chk({tag, "_busy_2"}, busy_2, 0);         chk({tag, "_done_2"}, done_2, 0);
        chk({tag, "_addr_A_4"}, addr_A_4, 0);     chk({tag, "_busy_4"}, busy_4, 0);
        chk({tag, "_out_valid_4"}, out_valid_4, 0); chk({tag, "_done_4"}, done_4, 0);
    endtask

    task automatic pulse_start(input int sel);
        if (sel == 0) start2 = 1'b1; else start4 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        start4 = 1'b0;
    endtask

    task automatic wait_done(input int sel);
        int seen;
        seen = 0;
        for (int n = 0; n < 300 && seen == 0; n++) begin
            @(negedge clk);
            if (((sel == 0) ? done_2 : done_4) == 1'b1) seen = 1;
        end
        chk((sel == 0) ? "d2_done_seen" : "d4_done_seen", seen, 1);
    endtask

    task automatic run_product(input int sel);
        push_product(sel, 0);
        pulse_start(sel);
        wait_done(sel);
        @(negedge clk);
    endtask

    task automatic load_example();
        for (int n = 0; n < 4; n++) begin
            a_m[0][n] = n + 1;
            b_m[0][n] = n + 5;
        end
    endtask

    initial begin
        int seen;
        reset_n = 1'b0;
        start2 = 1'b0;
        start4 = 1'b0;
`ifdef MATMUL_CTRL_STALL_EN
        stall2 = 1'b0;
`endif
        for (int s = 0; s < 2; s++) for (int n = 0; n < 16; n++) begin
            a_m[s][n] = 0;
            b_m[s][n] = 0;
        end
        repeat (2) @(negedge clk);
        check_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Worked example: 19,22,43,50.
        load_example();
        run_product(0);

        repeat (3) begin
            for (int n = 0; n < 4; n++) begin
                a_m[0][n] = int'($urandom_range(0, 15));
                b_m[0][n] = int'($urandom_range(0, 15));
            end
            run_product(0);
        end

        // Start held high: one product only, then a clean restart gives the same sequence.
        load_example();
        push_product(0, 0);
        start2 = 1'b1;
        seen = 0;
        for (int n = 0; n < 300 && seen == 0; n++) begin
            @(negedge clk);
            if (done_2) seen = 1;
        end
        chk("held_start_done_seen", seen, 1);
        start2 = 1'b0;
        repeat (4) @(negedge clk);
        run_product(0);

        // Reset during the 5th RUN cycle abandons the product.
        push_product(0, 0);
        pulse_start(0);
        repeat (4) @(posedge clk);
        #1 reset_n = 1'b0;
        #1 check_zero("midreset");
        tq2.delete();
        rq2.delete();
        bq2.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        run_product(0);

`ifdef MATMUL_CTRL_STALL_EN
        // Three-cycle stall while term 3 (addresses 0,1) is presented.
        push_product(0, 3);
        pulse_start(0);
        repeat (2) @(posedge clk);
        #1 stall2 = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("stall_addr_A", addr_A_2, 0);
            chk("stall_addr_B", addr_B_2, 1);
            chk("stall_en_PPReg", en_PPReg_2, 0);
            chk("stall_en_FDReg", en_FDReg_2, 0);
            chk("stall_out_valid", out_valid_2, 0);
        end
        stall2 = 1'b0;
        wait_done(0);
        @(negedge clk);
`endif

        // DIM=4: identity times random B reproduces B, then a fully random product.
        for (int n = 0; n < 16; n++) begin
            a_m[1][n] = (n % 5 == 0) ? 1 : 0;
            b_m[1][n] = int'($urandom_range(0, 255));
        end
        run_product(1);
        for (int n = 0; n < 16; n++) begin
            a_m[1][n] = int'($urandom_range(0, 31));
            b_m[1][n] = int'($urandom_range(0, 31));
        end
        run_product(1);

        repeat (4) @(negedge clk);
        chk("d2_terms_left", tq2.size(), 0);
        chk("d2_results_left", rq2.size(), 0);
        chk("d2_busy_left", bq2.size(), 0);
        chk("d4_terms_left", tq4.size(), 0);
        chk("d4_results_left", rq4.size(), 0);
        chk("d4_busy_left", bq4.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
